ram_scan_reader: RTL and testbench
==================================

RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
- REQ-001: The block SHALL have parameter TICK_DIV, default 50_000_000, meaning clock cycles per address advance (minimum 2).
- REQ-002: The block SHALL have parameter RD_LAT, default 1, meaning RAM read latency in cycles from rd_addr to valid rd_data (legal values 1 or 2).
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004: The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-005: The block SHALL have port enable, input, 1 bit: high to run the automatic scan, low to pause.
- REQ-006: The block SHALL have port rd_addr, output, ADDR_W bits: the read address driven to the 32x3 RAM read port.
- REQ-007: The block SHALL have port rd_data, input, DATA_W bits: RAM read data (q).
- REQ-008: The block SHALL have port disp_addr, output, ADDR_W bits: address of the currently displayed word.
- REQ-009: The block SHALL have port disp_data, output, DATA_W bits: captured data for disp_addr.
- REQ-010: The block SHALL have port disp_valid, output, 1 bit: high once disp_data holds a captured word.
- REQ-011: The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the address advances from 31 to 0.

Function
- REQ-012: The block SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE and HOLD.
- REQ-013: In IDLE with enable high, the next state SHALL be ISSUE.
- REQ-014: In ISSUE, rd_addr SHALL equal the scan address register, and the next state SHALL be WAIT.
- REQ-015: WAIT SHALL last exactly RD_LAT-1 additional cycles (zero for RD_LAT=1), after which the next state SHALL be CAPTURE.
- REQ-016: In CAPTURE, disp_data SHALL take rd_data and disp_addr SHALL take the scan address, disp_valid SHALL go high, and the next state SHALL be HOLD.
- REQ-017: HOLD SHALL count from 0 to TICK_DIV-1.
- REQ-018: At the HOLD terminal count, the scan address SHALL increment modulo 32 and the next state SHALL be ISSUE.
- REQ-019: Consecutive CAPTURE events SHALL be separated by exactly TICK_DIV+RD_LAT+1 cycles.
- REQ-020: The 31->0 increment SHALL assert wrap for exactly the cycle in which the address register updates.
- REQ-021: enable low in any non-IDLE state SHALL force IDLE on the next edge; the scan address, disp_* outputs and disp_valid SHALL be held, and the HOLD count SHALL be cleared.
- REQ-022: A return to running after a pause SHALL re-read the current address, not the next one.
- REQ-023: An in-flight read aborted by enable low SHALL NOT update disp_*.
- REQ-024: rd_addr SHALL continuously equal the scan address register in all states.

Reset
- REQ-025: reset_n low SHALL immediately force state IDLE, scan address 0, HOLD count 0, disp_addr 0, disp_data 0, disp_valid 0 and wrap 0.
- REQ-026: Reset asserted mid-read SHALL discard the read.
- REQ-027: After reset_n deasserts, the first CAPTURE SHALL occur RD_LAT+2 cycles after the first edge with enable high.

Configuration
- REQ-028: When macro RAM_SCAN_STEP_EN is defined, the block SHALL add input step (1 bit).
- REQ-029: With RAM_SCAN_STEP_EN defined, the block SHALL detect the rising edge of step internally with a registered previous value that resets to 0.
- REQ-030: With RAM_SCAN_STEP_EN defined, a rising edge on step while in IDLE with enable low SHALL increment the address modulo 32 (pulsing wrap on 31->0), run ISSUE, WAIT and CAPTURE once, and return to IDLE.
- REQ-031: With RAM_SCAN_STEP_EN defined, step edges outside IDLE or while enable is high SHALL be ignored.
- REQ-032: When RAM_SCAN_STEP_EN is undefined, the step port and its logic SHALL be absent, and the block SHALL otherwise behave identically.

Structure
- REQ-033: Package ram_scan_pkg SHALL hold localparams ADDR_W=5 and DATA_W=3, plus the FSM state enum typedef.
- REQ-034: The HOLD counter SHALL be a sub-module tick_divider, with clk, reset_n, clear and run inputs, a terminal-count pulse output, and parameter TICK_DIV.
- REQ-035: The RAM SHALL be external; this block contains no storage beyond its registers.

Verification (bench: TICK_DIV=4, RD_LAT=1, behavioural RAM preloaded with mem[i]=i%8)
- REQ-036: Reset, then enable=1 -> disp_valid rises 3 cycles later with disp_addr=0 and disp_data=0; the next capture comes 6 cycles later with addr=1 and data=1.
- REQ-037: Run a full scan -> wrap pulses once, one cycle wide, as the address goes 31->0; addr 9 captures data 1.
- REQ-038: enable=0 during WAIT at addr 5 -> disp stays at addr 4, data 4; after enable=1, addr 5 is captured with data 5.
- REQ-039: reset_n pulsed low for half a cycle during HOLD at addr 12 -> all outputs are 0 immediately and the scan restarts at addr 0.
- REQ-040: With RAM_SCAN_STEP_EN defined, enable=0 at disp_addr 31 and one step pulse -> disp_addr 0, data 0, wrap pulses once; step held high -> no further advance.
- REQ-041: With RD_LAT=2 -> the capture interval is 7 cycles and captured data still matches mem.

Source files
------------

// File: rtl/ram_scan_pkg.sv
// Shared widths and FSM state type for the RAM scan reader.
// Imported by ram_scan_reader and its testbench.
package ram_scan_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        HOLD
    } scanState_t;

    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/ram_scan_reader_tick_divider.sv
// Display hold counter: counts 0..TICK_DIV-1 while run is high.
// Raises tc combinationally on the terminal count.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = run && !clear && (count_q == LAST);

    // Clear wins over run so a pause always restarts the hold period from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Steps through a 32-word external RAM, holding each word on the display outputs.
// Optional manual single-step input enabled by defining RAM_SCAN_STEP_EN.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
`ifdef RAM_SCAN_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    scanState_t        state_q;
    logic [ADDR_W-1:0] scanAddr_q;
    logic [ADDR_W-1:0] dispAddr_q;
    logic [DATA_W-1:0] dispData_q;
    logic              dispValid_q;
    logic              wrap_q;
    logic [1:0]        waitCnt_q;
    logic              holdRun;
    logic              holdClear;
    logic              holdTc;
    logic              abort;

`ifdef RAM_SCAN_STEP_EN
    logic stepPrev_q;
    logic singleShot_q;
    logic stepRise;

    assign stepRise = step && !stepPrev_q;
    // A manual step runs its read to completion even though enable is low.
    assign abort    = !enable && !singleShot_q;
`else
    assign abort    = !enable;
`endif

    assign holdRun   = (state_q == CAPTURE) || (state_q == HOLD);
    assign holdClear = !enable;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_holdDiv (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (holdClear),
        .run    (holdRun),
        .tc     (holdTc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            scanAddr_q   <= '0;
            dispAddr_q   <= '0;
            dispData_q   <= '0;
            dispValid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            waitCnt_q    <= '0;
`ifdef RAM_SCAN_STEP_EN
            stepPrev_q   <= 1'b0;
            singleShot_q <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
`ifdef RAM_SCAN_STEP_EN
            stepPrev_q <= step;
`endif
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= ISSUE;
`ifdef RAM_SCAN_STEP_EN
                    end else if (stepRise) begin
                        scanAddr_q   <= nextAddr(scanAddr_q);
                        wrap_q       <= (scanAddr_q == {ADDR_W{1'b1}});
                        singleShot_q <= 1'b1;
                        state_q      <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        waitCnt_q <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 2'd1;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        dispAddr_q  <= scanAddr_q;
                        dispData_q  <= rd_data;
                        dispValid_q <= 1'b1;
`ifdef RAM_SCAN_STEP_EN
                        if (singleShot_q) begin
                            singleShot_q <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
`else
                        state_q <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (holdTc) begin
                        scanAddr_q <= nextAddr(scanAddr_q);
                        wrap_q     <= (scanAddr_q == {ADDR_W{1'b1}});
                        state_q    <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr    = scanAddr_q;
    assign disp_addr  = dispAddr_q;
    assign disp_data  = dispData_q;
    assign disp_valid = dispValid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: RD_LAT=1 and RD_LAT=2 instances, TICK_DIV=4.
// The single-step sequence runs only when RAM_SCAN_STEP_EN is defined.
module tb_ram_scan_reader;
    import ram_scan_pkg::*;

    localparam int TICK = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
`ifdef RAM_SCAN_STEP_EN
    logic step = 1'b0;
`endif

    logic [ADDR_W-1:0] rdAddr1, dispAddr1, rdAddr2, dispAddr2;
    logic [DATA_W-1:0] rdData1, dispData1, rdData2, dispData2;
    logic              dispValid1, wrap1, dispValid2, wrap2;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] stage2;

    int cyc;
    int checks;
    int errors;
    int wrapCount;
    int wrapCycle;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i % 8);
    end

    always @(posedge clk) begin
        rdData1 <= mem[rdAddr1];
        stage2  <= mem[rdAddr2];
        rdData2 <= stage2;
    end

    ram_scan_reader #(.TICK_DIV(TICK), .RD_LAT(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
`ifdef RAM_SCAN_STEP_EN
        .step      (step),
`endif
        .rd_addr   (rdAddr1),
        .rd_data   (rdData1),
        .disp_addr (dispAddr1),
        .disp_data (dispData1),
        .disp_valid(dispValid1),
        .wrap      (wrap1)
    );

    ram_scan_reader #(.TICK_DIV(TICK), .RD_LAT(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
`ifdef RAM_SCAN_STEP_EN
        .step      (step),
`endif
        .rd_addr   (rdAddr2),
        .rd_data   (rdData2),
        .disp_addr (dispAddr2),
        .disp_data (dispData2),
        .disp_valid(dispValid2),
        .wrap      (wrap2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) stepCycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_addr"}, int'(rdAddr1), 0);
        checkOutput({tag, "_disp_addr"}, int'(dispAddr1), 0);
        checkOutput({tag, "_disp_data"}, int'(dispData1), 0);
        checkOutput({tag, "_disp_valid"}, int'(dispValid1), 0);
        checkOutput({tag, "_wrap"}, int'(wrap1), 0);
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        wrapCount = 0;
        wrapCycle = -1;

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");

        reset_n = 1'b1;
        enable  = 1'b1;
        cyc     = 0;

        runTo(3);
        checkOutput("first_valid_early", int'(dispValid1), 0);
        runTo(4);
        checkOutput("first_valid", int'(dispValid1), 1);
        checkOutput("first_addr", int'(dispAddr1), 0);
        checkOutput("first_data", int'(dispData1), 0);
        checkOutput("lat2_valid_early", int'(dispValid2), 0);
        runTo(5);
        checkOutput("lat2_first_valid", int'(dispValid2), 1);
        checkOutput("lat2_first_addr", int'(dispAddr2), 0);
        runTo(9);
        checkOutput("second_capture_early", int'(dispAddr1), 0);
        runTo(10);
        checkOutput("second_addr", int'(dispAddr1), 1);
        checkOutput("second_data", int'(dispData1), 1);
        runTo(11);
        checkOutput("lat2_second_early", int'(dispAddr2), 0);
        runTo(12);
        checkOutput("lat2_second_addr", int'(dispAddr2), 1);
        checkOutput("lat2_second_data", int'(dispData2), 1);
        runTo(19);
        checkOutput("lat2_third_addr", int'(dispAddr2), 2);
        checkOutput("lat2_third_data", int'(dispData2), 2);
        checkOutput("lat2_wrap_idle", int'(wrap2), 0);

        while (cyc < 200) begin
            stepCycle();
            if (wrap1) begin
                wrapCount++;
                wrapCycle = cyc;
            end
            if (cyc == 58) begin
                checkOutput("addr9_addr", int'(dispAddr1), 9);
                checkOutput("addr9_data", int'(dispData1), 1);
            end
            if (cyc == 68) begin
                checkOutput("lat2_addr9_addr", int'(dispAddr2), 9);
                checkOutput("lat2_addr9_data", int'(dispData2), 1);
            end
            if (cyc == 190) begin
                checkOutput("addr31_addr", int'(dispAddr1), 31);
                checkOutput("addr31_data", int'(dispData1), 7);
            end
            if (cyc == 193) checkOutput("wrap_rd_addr", int'(rdAddr1), 0);
            if (cyc == 196) begin
                checkOutput("lap2_addr0_addr", int'(dispAddr1), 0);
                checkOutput("lap2_addr0_data", int'(dispData1), 0);
            end
        end
        checkOutput("wrap_count", wrapCount, 1);
        checkOutput("wrap_cycle", wrapCycle, 193);

        runTo(224);
        enable = 1'b0;
        runTo(230);
        checkOutput("pause_disp_addr", int'(dispAddr1), 4);
        checkOutput("pause_disp_data", int'(dispData1), 4);
        checkOutput("pause_disp_valid", int'(dispValid1), 1);
        checkOutput("pause_rd_addr", int'(rdAddr1), 5);
        enable = 1'b1;
        runTo(233);
        checkOutput("resume_early", int'(dispAddr1), 4);
        runTo(234);
        checkOutput("resume_addr", int'(dispAddr1), 5);
        checkOutput("resume_data", int'(dispData1), 5);

        runTo(277);
        checkOutput("hold12_addr", int'(dispAddr1), 12);
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        #3;
        reset_n = 1'b1;
        runTo(280);
        checkOutput("restart_valid_early", int'(dispValid1), 0);
        runTo(281);
        checkOutput("restart_valid", int'(dispValid1), 1);
        checkOutput("restart_addr", int'(dispAddr1), 0);
        checkOutput("restart_data", int'(dispData1), 0);
        runTo(287);
        checkOutput("restart_next_addr", int'(dispAddr1), 1);

`ifdef RAM_SCAN_STEP_EN
        runTo(467);
        checkOutput("step_pre_addr", int'(dispAddr1), 31);
        runTo(468);
        enable = 1'b0;
        runTo(472);
        checkOutput("step_idle_addr", int'(dispAddr1), 31);
        step = 1'b1;
        wrapCount = 0;
        while (cyc < 490) begin
            stepCycle();
            if (wrap1) wrapCount++;
            if (cyc == 476) begin
                checkOutput("step_capture_addr", int'(dispAddr1), 0);
                checkOutput("step_capture_data", int'(dispData1), 0);
            end
        end
        checkOutput("step_wrap_count", wrapCount, 1);
        checkOutput("step_held_rd_addr", int'(rdAddr1), 0);
        checkOutput("step_held_disp_addr", int'(dispAddr1), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
